// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: demand-driven NS/EW/pedestrian phase sequencer; optional TLC_EMERG_PREEMPT_EN adds emergency preemption.
module intersection_phase_scheduler #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
`ifdef TLC_EMERG_PREEMPT_EN
  input  logic       emerg_req,
  input  logic       emerg_dir,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } state_t;
  localparam logic [CNT_W-1:0] GMIN1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK1 = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] TMAX  = '1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;
  logic             last_dir_q, last_dir_d;
  logic [2:0]       ns_light_q, ns_light_d, ew_light_q, ew_light_d;
  logic             walk_q, walk_d, ped_ack_q, ped_ack_d;
  logic             emg, edir;
`ifdef TLC_EMERG_PREEMPT_EN
  assign emg  = emerg_req;
  assign edir = emerg_dir;
`else
  assign emg  = 1'b0;
  assign edir = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      NS_GREEN:  if (tick && (emg ? edir : (car_ew | ped_pending_q) && timer_q >= (car_ns ? GMAX1 : GMIN1))) state_d = NS_YELLOW;
      EW_GREEN:  if (tick && (emg ? !edir : (car_ns | ped_pending_q) && timer_q >= (car_ew ? GMAX1 : GMIN1))) state_d = EW_YELLOW;
      NS_YELLOW: if (tick && timer_q == YEL1) state_d = ALLRED_A;
      EW_YELLOW: if (tick && timer_q == YEL1) state_d = ALLRED_B;
      ALLRED_A, ALLRED_B: if (tick && timer_q == AR1) begin
        state_d    = emg ? (edir ? EW_GREEN : NS_GREEN) : ped_pending_q ? PED_WALK : (state_q == ALLRED_A ? EW_GREEN : NS_GREEN);
        last_dir_d = state_q == ALLRED_B;
      end
      PED_WALK:  if (tick && (emg || timer_q == WALK1))
        state_d = emg ? (edir ? EW_GREEN : NS_GREEN) : (last_dir_q ? NS_GREEN : EW_GREEN);
      default:   state_d = NS_GREEN;
    endcase
    timer_d       = state_d != state_q ? '0 : (tick && timer_q != TMAX) ? timer_q + 1'b1 : timer_q;
    ped_ack_d     = state_d == PED_WALK && state_q != PED_WALK;
    ped_pending_d = ped_ack_d ? 1'b0 : (ped_req && state_q != PED_WALK) ? 1'b1 : ped_pending_q;
    walk_d        = state_d == PED_WALK;
    ns_light_d    = state_d == NS_GREEN ? 3'b001 : state_d == NS_YELLOW ? 3'b010 : 3'b100;
    ew_light_d    = state_d == EW_GREEN ? 3'b001 : state_d == EW_YELLOW ? 3'b010 : 3'b100;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NS_GREEN;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      last_dir_q    <= 1'b0;
      ns_light_q    <= 3'b001;
      ew_light_q    <= 3'b100;
      walk_q        <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      last_dir_q    <= last_dir_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      walk_q        <= walk_d;
      ped_ack_q     <= ped_ack_d;
    end
  end
  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign ped_ack  = ped_ack_q;
  assign phase    = state_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: vector table plus directed sequences for the phase scheduler.
module tb_intersection_phase_scheduler;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b1, car_ns = 1'b0, car_ew = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic walk, ped_ack;
  int checks = 0, errors = 0;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
`ifdef TLC_EMERG_PREEMPT_EN
  logic emerg_req = 1'b0, emerg_dir = 1'b0;
`endif
  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
`ifdef TLC_EMERG_PREEMPT_EN
    .emerg_req(emerg_req), .emerg_dir(emerg_dir),
`endif
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rst, cns, cew;
    logic [10:0] exp;
  } vec_t;
  vec_t tv[15];
  function automatic vec_t v(input logic r, input logic cns, input logic cew, input logic [2:0] n, input logic [2:0] e, input logic [2:0] ph);
    return '{r, cns, cew, {n, e, 2'b00, ph}};
  endfunction
  function automatic logic [10:0] obs();
    return {ns_light, ew_light, walk, ped_ack, phase};
  endfunction
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask
  initial begin
    int n, bad;
    tv[0]  = v(1, 0, 1, G, R, 0);
    tv[1]  = v(0, 0, 1, G, R, 0);
    tv[2]  = v(0, 0, 1, G, R, 0);
    tv[3]  = v(0, 0, 1, G, R, 0);
    tv[4]  = v(0, 0, 1, Y, R, 1);
    tv[5]  = v(0, 0, 1, Y, R, 1);
    tv[6]  = v(0, 0, 1, R, R, 2);
    tv[7]  = v(0, 0, 1, R, G, 3);
    tv[8]  = v(0, 1, 0, R, G, 3);
    tv[9]  = v(0, 1, 0, R, G, 3);
    tv[10] = v(0, 1, 0, R, G, 3);
    tv[11] = v(0, 1, 0, R, Y, 4);
    tv[12] = v(0, 1, 0, R, Y, 4);
    tv[13] = v(0, 1, 0, R, R, 5);
    tv[14] = v(0, 1, 0, G, R, 0);
    #2;
    for (int i = 0; i < 15; i++) begin
      reset = tv[i].rst;
      car_ns = tv[i].cns;
      car_ew = tv[i].cew;
      edge1();
      chk($sformatf("table[%0d]", i), obs(), tv[i].exp);
    end
    // both roads busy: each green runs to GREEN_MAX
    car_ns = 1; car_ew = 1;
    do_reset();
    run(11); chk("max_ns_green_end", obs(), {G, R, 5'd0});
    run(1);  chk("max_ns_yellow", obs(), {Y, R, 5'd1});
    run(2);  chk("max_allred_a", obs(), {R, R, 5'd2});
    run(1);  chk("max_ew_green", obs(), {R, G, 5'd3});
    run(11); chk("max_ew_green_end", obs(), {R, G, 5'd3});
    run(1);  chk("max_ew_yellow", obs(), {R, Y, 5'd4});
    // pedestrian service, ped_req during walk ignored
    car_ns = 0; car_ew = 0;
    do_reset();
    ped_req = 1; edge1(); ped_req = 0;
    run(2);  chk("ped_ns_green", obs(), {G, R, 5'd0});
    run(1);  chk("ped_yellow", obs(), {Y, R, 5'd1});
    run(2);  chk("ped_allred", obs(), {R, R, 5'd2});
    run(1);  chk("ped_ack_entry", obs(), {R, R, 2'b11, 3'd6});
    ped_req = 1; edge1(); ped_req = 0;
    chk("ped_walk2", obs(), {R, R, 2'b10, 3'd6});
    run(3);  chk("ped_walk5", obs(), {R, R, 2'b10, 3'd6});
    run(1);  chk("ped_to_ew", obs(), {R, G, 5'd3});
    run(8);  chk("ped_req_in_walk_dropped", obs(), {R, G, 5'd3});
    // long idle: timer must saturate rather than wrap
    do_reset();
    bad = 0;
    for (int i = 0; i < 257; i++) begin
      edge1();
      if (obs() !== {G, R, 5'd0}) bad++;
    end
    chk("idle_hold_bad_cycles", 11'(bad), 11'd0);
    car_ew = 1; edge1();
    chk("saturated_exit", obs(), {Y, R, 5'd1});
    // tick every third cycle
    do_reset();
    n = 0;
    for (int k = 0; k < 24; k++) begin
      tick = (k % 3 == 2);
      edge1();
      if (tick) n++;
      chk($sformatf("slow_tick[%0d]", k), 11'(phase), 11'(n < 4 ? 0 : n < 6 ? 1 : n < 7 ? 2 : 3));
    end
    tick = 1;
    // reset mid EW_YELLOW
    do_reset();
    run(7); car_ns = 1; car_ew = 0;
    run(5); chk("pre_reset_ew_yellow", obs(), {R, Y, 5'd4});
    do_reset(); chk("reset_from_ew_yellow", obs(), {G, R, 5'd0});
    // reset mid PED_WALK clears pending request
    car_ns = 0; car_ew = 0;
    ped_req = 1; edge1(); ped_req = 0;
    run(7); chk("pre_reset_walk", obs(), {R, R, 2'b10, 3'd6});
    do_reset(); chk("reset_from_walk", obs(), {G, R, 5'd0});
    run(10); chk("no_pending_after_reset", obs(), {G, R, 5'd0});
`ifdef TLC_EMERG_PREEMPT_EN
    do_reset();
    edge1();
    emerg_req = 1; emerg_dir = 1; edge1();
    chk("emerg_ns_yellow", obs(), {Y, R, 5'd1});
    run(1); chk("emerg_yellow_full", obs(), {Y, R, 5'd1});
    run(1); chk("emerg_allred", obs(), {R, R, 5'd2});
    run(1); chk("emerg_ew_green", obs(), {R, G, 5'd3});
    car_ns = 1; run(20); chk("emerg_ew_hold", obs(), {R, G, 5'd3});
    emerg_req = 0; car_ns = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
